// File: rtl/truth_table_checker_if.sv
// Vector/response handshake and status bundle between a DUT harness and the truth-table checker.
// The harness drives master; the checker is the slave.
interface truth_table_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);
  logic              start;
  logic              vec_valid;
  logic [N_IN-1:0]   vec_idx;
  logic [N_OUT-1:0]  resp;
  logic              vec_ready;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              first_err_valid;
  logic [N_IN-1:0]   first_err_idx;
  logic              dup_err;
  logic              timeout;

  modport master (
    output start, vec_valid, vec_idx, resp,
    input  vec_ready, busy, done, pass, err_count,
           first_err_valid, first_err_idx, dup_err, timeout
  );

  modport slave (
    input  start, vec_valid, vec_idx, resp,
    output vec_ready, busy, done, pass, err_count,
           first_err_valid, first_err_idx, dup_err, timeout
  );
endinterface

// File: rtl/truth_table_checker.sv
// Compares (index, response) pairs against EXP_TABLE, tracks coverage, dups and idle timeout.
// Status lags a transfer by one cycle; vec_ready is high only while collecting.
module truth_table_checker #(
  parameter int                           N_IN      = 3,
  parameter int                           N_OUT     = 2,
  parameter logic [(2**N_IN)*N_OUT-1:0]   EXP_TABLE = 16'hD668,
  parameter int                           TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_checker_if.slave  bus
);

  localparam int              NV      = 2**N_IN;
  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [N_IN:0]   ERR_MAX = (N_IN + 1)'(NV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [NV-1:0]    r_seen;
  logic [CW-1:0]    r_idle_cnt;
  logic [N_IN:0]    r_err_count;
  logic             r_first_err_valid;
  logic [N_IN-1:0]  r_first_err_idx;
  logic             r_dup_err;
  logic             r_timeout;

  logic             w_collect;
  logic             w_xfer;
  logic             w_is_new;
  logic             w_mismatch;
  logic             w_cov_done;
  logic             w_idle_expire;
  logic             w_clear;
  logic [NV-1:0]    w_idx_onehot;
  logic [N_OUT-1:0] w_exp;

  assign w_collect     = (r_state == S_COLLECT);
  assign w_xfer        = w_collect && bus.vec_valid;
  assign w_idx_onehot  = NV'(1) << bus.vec_idx;
  assign w_is_new      = w_xfer && !r_seen[bus.vec_idx];
  assign w_exp         = EXP_TABLE[int'(bus.vec_idx)*N_OUT +: N_OUT];
  assign w_mismatch    = (bus.resp != w_exp);
  assign w_cov_done    = w_is_new && ((r_seen | w_idx_onehot) == {NV{1'b1}});
  // A transfer on the expiring edge wins, so expiry only happens on idle cycles.
  assign w_idle_expire = w_collect && !w_xfer && (r_idle_cnt == CNT_LAST);
  assign w_clear       = !w_collect && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.start) w_next_state = S_COLLECT;
      S_COLLECT: if (w_cov_done || w_idle_expire) w_next_state = S_DONE;
      S_DONE:    if (bus.start) w_next_state = S_COLLECT;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.vec_ready       = 1'b0;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.pass            = 1'b0;
    bus.err_count       = r_err_count;
    bus.first_err_valid = r_first_err_valid;
    bus.first_err_idx   = r_first_err_idx;
    bus.dup_err         = r_dup_err;
    bus.timeout         = r_timeout;
    unique case (r_state)
      S_COLLECT: begin
        bus.vec_ready = 1'b1;
        bus.busy      = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.pass = (r_err_count == '0) && !r_dup_err && !r_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_seen            <= '0;
      r_idle_cnt        <= '0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_dup_err         <= 1'b0;
      r_timeout         <= 1'b0;
    end else if (w_xfer) begin
      r_idle_cnt <= '0;
      if (!w_is_new) begin
        r_dup_err <= 1'b1;
      end else begin
        r_seen <= r_seen | w_idx_onehot;
        if (w_mismatch) begin
          if (r_err_count != ERR_MAX) begin
            r_err_count <= r_err_count + 1'b1;
          end
          if (!r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_idx   <= bus.vec_idx;
          end
        end
      end
    end else if (w_collect) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_idle_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a behavioural reference checked every cycle,
// plus literal expectations taken from hand-worked runs.
module tb_truth_table_checker;

  localparam int N_IN    = 3;
  localparam int N_OUT   = 2;
  localparam int NV      = 8;
  localparam int TIMEOUT = 64;

  localparam int MD_IDLE    = 0;
  localparam int MD_COLLECT = 1;
  localparam int MD_DONE    = 2;

  logic clk;
  logic rst_n;

  truth_table_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus();

  truth_table_checker #(
    .N_IN(N_IN), .N_OUT(N_OUT), .EXP_TABLE(16'hD668), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference: majority and parity of {A,B,C}, independent of the packed table.
  function automatic logic [1:0] golden(input logic [2:0] idx);
    logic a, b, c;
    {a, b, c} = idx;
    return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
  endfunction

  int   m_mode;
  bit   m_seen [NV];
  int   m_nseen;
  int   m_err;
  bit   m_fev;
  int   m_fidx;
  bit   m_dup;
  bit   m_tmo;
  int   m_idle;

  function automatic void model_clear();
    for (int i = 0; i < NV; i++) m_seen[i] = 1'b0;
    m_nseen = 0; m_err = 0; m_fev = 0; m_fidx = 0;
    m_dup = 0; m_tmo = 0; m_idle = 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = MD_IDLE;
      model_clear();
    end else if (m_mode != MD_COLLECT) begin
      if (bus.start) begin
        m_mode = MD_COLLECT;
        model_clear();
      end
    end else if (bus.vec_valid) begin
      m_idle = 0;
      if (m_seen[bus.vec_idx]) begin
        m_dup = 1;
      end else begin
        m_seen[bus.vec_idx] = 1;
        m_nseen++;
        if (bus.resp != golden(bus.vec_idx)) begin
          if (m_err < NV) m_err++;
          if (!m_fev) begin
            m_fev  = 1;
            m_fidx = int'(bus.vec_idx);
          end
        end
        if (m_nseen == NV) m_mode = MD_DONE;
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_tmo  = 1;
        m_mode = MD_DONE;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_vec_ready", 32'(bus.vec_ready), 32'(m_mode == MD_COLLECT));
      check("m_busy",      32'(bus.busy),      32'(m_mode == MD_COLLECT));
      check("m_done",      32'(bus.done),      32'(m_mode == MD_DONE));
      check("m_pass",      32'(bus.pass),
            32'(m_mode == MD_DONE && m_err == 0 && !m_dup && !m_tmo));
      check("m_err_count", 32'(bus.err_count), 32'(m_err));
      check("m_fev",       32'(bus.first_err_valid), 32'(m_fev));
      check("m_fidx",      32'(bus.first_err_idx),   32'(m_fidx));
      check("m_dup",       32'(bus.dup_err), 32'(m_dup));
      check("m_timeout",   32'(bus.timeout), 32'(m_tmo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input int idx, input logic [1:0] r);
    bus.vec_valid = 1'b1;
    bus.vec_idx   = 3'(idx);
    bus.resp      = r;
    tick();
    bus.vec_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  32'(bus.vec_ready), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_pass"}, 32'(bus.pass), 0);
    check({tag, "_err"},  32'(bus.err_count), 0);
    check({tag, "_fev"},  32'(bus.first_err_valid), 0);
    check({tag, "_fidx"}, 32'(bus.first_err_idx), 0);
    check({tag, "_dup"},  32'(bus.dup_err), 0);
    check({tag, "_tmo"},  32'(bus.timeout), 0);
  endtask

  logic [1:0] good [NV];
  int         dup_order [9];

  initial begin
    good      = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    dup_order = '{7, 3, 3, 0, 1, 2, 4, 5, 6};
    rst_n = 1'b0;
    bus.start = 1'b0; bus.vec_valid = 1'b0; bus.vec_idx = '0; bus.resp = '0;
    tick();
    tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    check_all_zero("rst");

    // Run 1: all correct, back-to-back.
    pulse_start();
    check("t1_rdy_after_start", 32'(bus.vec_ready), 1);
    check("t1_busy_after_start", 32'(bus.busy), 1);
    for (int i = 0; i < NV; i++) begin
      if (i == NV - 1) check("t1_not_done_early", 32'(bus.done), 0);
      send(i, good[i]);
    end
    check("t1_done", 32'(bus.done), 1);
    check("t1_pass", 32'(bus.pass), 1);
    check("t1_err",  32'(bus.err_count), 0);
    check("t1_fev",  32'(bus.first_err_valid), 0);
    check("t1_rdy_low", 32'(bus.vec_ready), 0);

    // Run 2: idx5 -> 10, idx6 -> 00.
    pulse_start();
    for (int i = 0; i < NV; i++)
      send(i, (i == 5) ? 2'b10 : (i == 6) ? 2'b00 : good[i]);
    check("t2_done", 32'(bus.done), 1);
    check("t2_err",  32'(bus.err_count), 2);
    check("t2_fidx", 32'(bus.first_err_idx), 5);
    check("t2_fev",  32'(bus.first_err_valid), 1);
    check("t2_pass", 32'(bus.pass), 0);

    // Run 3: duplicate idx 3.
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("t3_not_done_before_6", 32'(bus.done), 0);
      send(dup_order[i], good[dup_order[i]]);
    end
    check("t3_done", 32'(bus.done), 1);
    check("t3_dup",  32'(bus.dup_err), 1);
    check("t3_err",  32'(bus.err_count), 0);
    check("t3_pass", 32'(bus.pass), 0);

    // Run 4: idx 0..6 then idle until timeout on the 64th idle edge.
    pulse_start();
    for (int i = 0; i < NV - 1; i++) send(i, good[i]);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t4_not_done_63", 32'(bus.done), 0);
    check("t4_tmo_low_63",  32'(bus.timeout), 0);
    tick();
    check("t4_done", 32'(bus.done), 1);
    check("t4_tmo",  32'(bus.timeout), 1);
    check("t4_pass", 32'(bus.pass), 0);

    // Run 5: abort by reset mid-run, then a clean run.
    pulse_start();
    for (int i = 0; i < 4; i++) send(i, (i == 2) ? 2'b11 : good[i]);
    check("t5_err_mid", 32'(bus.err_count), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("t5_rst");
    pulse_start();
    for (int i = 0; i < NV; i++) send(i, good[i]);
    check("t5_pass", 32'(bus.pass), 1);

    // Run 6: vec_valid in DONE and IDLE, start during COLLECT.
    bus.vec_valid = 1'b1; bus.vec_idx = 3'd0; bus.resp = 2'b11;
    tick(); tick();
    check("t6_done_hold", 32'(bus.done), 1);
    check("t6_rdy_done",  32'(bus.vec_ready), 0);
    check("t6_pass_hold", 32'(bus.pass), 1);
    bus.vec_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.vec_valid = 1'b1;
    tick(); tick();
    check("t6_rdy_idle",  32'(bus.vec_ready), 0);
    check("t6_busy_idle", 32'(bus.busy), 0);
    bus.vec_valid = 1'b0;
    pulse_start();
    send(0, 2'b01);
    bus.start = 1'b1;
    send(1, good[1]);
    bus.start = 1'b0;
    check("t6_err_kept",  32'(bus.err_count), 1);
    check("t6_fidx_kept", 32'(bus.first_err_idx), 0);
    for (int i = 2; i < NV; i++) send(i, good[i]);
    check("t6_done", 32'(bus.done), 1);
    check("t6_err",  32'(bus.err_count), 1);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Response-side companion to the combinational stimulus benches: a synthesizable checker that accepts (input-vector index, observed outputs) pairs from a DUT harness, compares each against a parameterized expected truth table, tracks coverage of all 2^N_IN input combinations, and reports pass/fail with an error count, the first failing index, and a timeout. It sits after the DUT outputs in a self-checking wrapper, so exhaustive-vector runs need no waveform inspection.

## Interface
- N_IN, 3, DUT input count; index space is 2^N_IN vectors
- N_OUT, 2, DUT output count
- EXP_TABLE, 16'hD668, expected outputs packed as EXP_TABLE[idx*N_OUT +: N_OUT], width (2^N_IN)*N_OUT. The default encodes {F1,F2} = {A^B^C, majority(A,B,C)} with idx = {A,B,C}.
- TIMEOUT, 64, maximum idle cycles in COLLECT without an accepted vector
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a new check run (pulse)
- vec_valid  in  1  vec_idx/resp are valid this cycle
- vec_idx  in  N_IN  input combination that produced resp
- resp  in  N_OUT  observed DUT outputs for vec_idx
- vec_ready  out  1  checker accepts a vector this cycle
- busy  out  1  run in progress
- done  out  1  run finished; holds until the next start or reset
- pass  out  1  valid when done: all vectors seen, zero mismatches, no duplicates, no timeout
- err_count  out  N_IN+1  mismatch count, saturating at 2^N_IN
- first_err_valid  out  1  at least one mismatch recorded
- first_err_idx  out  N_IN  vec_idx of the first mismatch
- dup_err  out  1  sticky; an already-covered index was presented again
- timeout  out  1  sticky; TIMEOUT expired before coverage completed

## Operation
- FSM states: IDLE, COLLECT, DONE.
- IDLE: vec_ready=0, busy=0. start moves to COLLECT and clears the seen bitmap, err_count, first_err_*, dup_err, timeout, done, pass, and the idle counter.
- COLLECT: vec_ready=1, busy=1. A transfer is vec_valid && vec_ready.
  - On a transfer with seen[vec_idx]=0:
    - Set seen[vec_idx].
    - If resp != EXP_TABLE slice, increment err_count (saturating). If first_err_valid=0, latch first_err_idx=vec_idx and set first_err_valid.
  - On a transfer with seen[vec_idx]=1: set dup_err. The vector is neither compared nor counted.
  - Any transfer resets the idle counter. Otherwise the counter increments.
  - Exit to DONE when the seen bitmap becomes all-ones, or when the idle counter reaches TIMEOUT (sets timeout).
- DONE: vec_ready=0, busy=0, done=1. pass = (err_count==0) && !dup_err && !timeout. start re-enters COLLECT with all state cleared, exactly as from IDLE.
- start while in COLLECT is ignored.
- vec_valid outside COLLECT is ignored.

## Timing
- Reset (rst_n=0 at a rising edge) forces:
  - state to IDLE
  - every output to 0: vec_ready, busy, done, pass, err_count, first_err_valid, first_err_idx, dup_err, timeout
  - the seen bitmap and idle counter to 0
- Reset applied mid-run aborts the run with no done pulse.
- start sampled at edge t: vec_ready=1 and busy=1 from t+1.
- Status latency from a transfer sampled at edge t:
  - err_count, first_err_*, and dup_err update at t+1.
  - If this transfer completes coverage: state=DONE at t+1, so done=1, pass valid, and vec_ready=0 at t+1.
- Timeout:
  - Each non-transfer cycle in COLLECT increments the counter.
  - The edge at which the counter reaches TIMEOUT also enters DONE, so timeout=1 and done=1 on the same cycle.
  - A transfer on that same edge takes priority: it is processed and the counter resets.
- Minimum run is 2^N_IN back-to-back transfers, giving done at start+1+2^N_IN cycles.

## Test plan
- Reset, start, then the 8 vectors in order idx 0..7 with resp 00,10,10,01,10,01,01,11 back-to-back -> done after the 8th transfer, pass=1, err_count=0, first_err_valid=0.
- Same run with idx 5 answered resp=10 and idx 6 answered resp=00 -> err_count=2, first_err_idx=5, pass=0.
- Vectors in order 7,3,3,0,1,2,4,5,6 -> dup_err=1. Done after idx 6. err_count=0, pass=0.
- Start, send idx 0..6, then vec_valid=0 for 64 cycles -> timeout=1, done=1, pass=0, done on the 64th idle edge.
- Mid-run: 4 vectors, then rst_n=0 for 1 cycle -> all outputs 0. A new start plus 8 correct vectors -> pass=1.
- start pulsed during COLLECT, and vec_valid held high in IDLE/DONE -> no state change, vec_ready stays 0 outside COLLECT.
